hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage 64-bit-PC core.
- Sequences the IF/ID register (IF_write enable, flush), the PC write enable, the ID/EX bubble/flush and a global pipeline hold.
- Resolves three conditions: load-use hazards, taken-branch flushes, and data-memory wait states with a watchdog.
- Sits between decode and the pipeline registers; it is the only driver of their stall/flush controls.

Parameters:
- FLUSH_CYCLES, 2, total cycles IF_ID_flush stays asserted after a taken branch (including the detect cycle); legal range 1..15.
- TIMEOUT, 64, maximum MEM_WAIT cycles before abort; legal range 2..1023.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- IF_ID_instruction  in  32  instruction in decode. Fields: opcode [6:0], rs1 [19:15], rs2 [24:20].
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_rd  in  5  destination register of the instruction in EX.
- branch_taken  in  1  EX-stage branch/jump redirect this cycle.
- dmem_req  in  1  MEM stage is issuing a data-memory access.
- dmem_ready  in  1  data memory completes the access this cycle.
- PC_write  out  1  PC register load enable.
- IF_write  out  1  IF/ID load enable.
- IF_ID_flush  out  1  IF/ID loads NOP (0x00000013).
- ID_EX_bubble  out  1  zero the ID/EX control fields.
- ID_EX_flush  out  1  squash the instruction entering ID/EX.
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- timeout_err  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- States: RUN, FLUSH, MEM_WAIT.
- Registered: state, flush_cnt (4b), wait_cnt (10b), timeout_err. All other outputs are combinational from state and inputs, so a stall takes effect in the same cycle.
- Reset (sampled at clk edge):
  - state=RUN, counters=0, timeout_err=0.
  - While reset=1, all outputs are 0 (including PC_write and IF_write).
- Default output values: PC_write=1, IF_write=1, everything else 0.
- Load-use detect (load_use):
  - Condition: ID_EX_MemRead && ID_EX_rd!=0 && ((uses_rs1 && rs1==ID_EX_rd) || (uses_rs2 && rs2==ID_EX_rd)).
  - uses_rs1 = 0 for opcodes 0110111, 0010111, 1101111; otherwise 1.
  - uses_rs2 = 1 only for opcodes 0110011, 0100011, 1100011.
- RUN, priority order (first match wins):
  1. branch_taken:
     - Outputs: IF_ID_flush=1, ID_EX_flush=1, IF_write=0, PC_write=1 (redirect).
     - If FLUSH_CYCLES>1: flush_cnt<=FLUSH_CYCLES-2, next state FLUSH.
  2. dmem_req && !dmem_ready:
     - Outputs: pipe_hold=1, PC_write=0, IF_write=0.
     - wait_cnt<=1, next state MEM_WAIT.
  3. load_use:
     - Outputs: PC_write=0, IF_write=0, ID_EX_bubble=1.
     - Stay in RUN. The bubble clears MemRead next cycle, giving exactly one stall cycle.
  4. Otherwise: default outputs.
  - dmem_req && dmem_ready together is a zero-wait access: no stall.
- FLUSH:
  - Outputs: IF_ID_flush=1, IF_write=0, PC_write=1. load_use and ID_EX_bubble are suppressed.
  - If dmem_req && !dmem_ready: pipe_hold=1, PC_write=0, flush_cnt frozen, stay in FLUSH.
  - Else if flush_cnt==0: next state RUN. Otherwise flush_cnt decrements.
  - A new branch_taken in FLUSH reloads flush_cnt<=FLUSH_CYCLES-2 and asserts ID_EX_flush.
- MEM_WAIT:
  - Outputs: pipe_hold=1, PC_write=0, IF_write=0. branch_taken and load_use are ignored (EX is frozen, so they are re-evaluated in RUN).
  - If dmem_ready: outputs revert to default that same cycle, next state RUN, wait_cnt<=0.
  - Else if wait_cnt==TIMEOUT-1: timeout_err<=1 for one cycle, next state RUN, wait_cnt<=0.
  - Else wait_cnt increments.
  - dmem_ready on the expiry cycle counts as completion (no error).
- Reset asserted mid-FLUSH or mid-MEM_WAIT aborts immediately; no pulse is emitted.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds three output ports, each 32b, saturating at 0xFFFFFFFF:
  - perf_lu_stalls: cycles with load-use stall.
  - perf_flushes: count of branch_taken acceptances.
  - perf_mem_wait: cycles with pipe_hold=1.
- Counters clear on reset.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_instruction=0x00528333 (add x6,x5,x5) -> PC_write=0, IF_write=0, ID_EX_bubble=1 for exactly 1 cycle; same with rd=0 -> no stall.
- No false stall: ID_EX_rd=5 with LUI x5 in decode (0x000012B7) -> no stall. SW with rs2=5 (0x00502023) -> stall.
- Branch: branch_taken=1 for 1 cycle, FLUSH_CYCLES=2 -> IF_ID_flush=1 for 2 cycles, ID_EX_flush=1 in the first only, PC_write=1 both cycles.
- Memory wait: dmem_req=1, dmem_ready low for 3 cycles then high -> pipe_hold=1 for 3 cycles, released in the ready cycle, timeout_err stays 0.
- Timeout: dmem_req=1, dmem_ready=0 permanently, TIMEOUT=64 -> hold for 64 cycles, timeout_err pulses at cycle 64, state returns to RUN.
- Reset mid-MEM_WAIT at cycle 10 -> next cycle all outputs are 0; after release, defaults with no timeout_err.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and data-memory waits with a watchdog.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_ID_instruction,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_rd,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        PC_write,
  output logic        IF_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        ID_EX_flush,
  output logic        pipe_hold,
  output logic        timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_flushes,
  output logic [31:0] perf_mem_wait
`endif
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  localparam logic [3:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam logic [9:0] WAIT_LAST    = 10'(TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [3:0] flush_cnt_reg, flush_cnt_next;
  logic [9:0] wait_cnt_reg, wait_cnt_next;
  logic       timeout_reg, timeout_next;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       uses_rs1, uses_rs2, load_use, mem_stall;
  logic       unused_instr_bits;

  assign opcode   = IF_ID_instruction[6:0];
  assign rs1      = IF_ID_instruction[19:15];
  assign rs2      = IF_ID_instruction[24:20];
  assign unused_instr_bits = ^{IF_ID_instruction[31:25], IF_ID_instruction[14:7]};

  assign uses_rs1 = !(opcode == 7'b0110111 || opcode == 7'b0010111 || opcode == 7'b1101111);
  assign uses_rs2 = (opcode == 7'b0110011 || opcode == 7'b0100011 || opcode == 7'b1100011);
  assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                    ((uses_rs1 && rs1 == ID_EX_rd) || (uses_rs2 && rs2 == ID_EX_rd));
  assign mem_stall = dmem_req && !dmem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RUN;
      flush_cnt_reg <= 4'd0;
      wait_cnt_reg  <= 10'd0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    PC_write       = 1'b1;
    IF_write       = 1'b1;
    IF_ID_flush    = 1'b0;
    ID_EX_bubble   = 1'b0;
    ID_EX_flush    = 1'b0;
    pipe_hold      = 1'b0;
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    timeout_next   = 1'b0;

    unique case (state_reg)
      RUN: begin
        if (branch_taken) begin
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
          IF_write    = 1'b0;
          if (FLUSH_CYCLES > 1) begin
            flush_cnt_next = FLUSH_RELOAD;
            state_next     = FLUSH;
          end
        end else if (mem_stall) begin
          pipe_hold     = 1'b1;
          PC_write      = 1'b0;
          IF_write      = 1'b0;
          wait_cnt_next = 10'd1;
          state_next    = MEM_WAIT;
        end else if (load_use) begin
          PC_write     = 1'b0;
          IF_write     = 1'b0;
          ID_EX_bubble = 1'b1;
        end
      end

      FLUSH: begin
        IF_ID_flush = 1'b1;
        IF_write    = 1'b0;
        if (branch_taken) begin
          ID_EX_flush    = 1'b1;
          flush_cnt_next = FLUSH_RELOAD;
        end else if (mem_stall) begin
          // Freeze the flush countdown until the memory stage can advance.
          pipe_hold = 1'b1;
          PC_write  = 1'b0;
        end else if (flush_cnt_reg == 4'd0) begin
          state_next = RUN;
        end else begin
          flush_cnt_next = flush_cnt_reg - 4'd1;
        end
      end

      MEM_WAIT: begin
        if (dmem_ready) begin
          state_next    = RUN;
          wait_cnt_next = 10'd0;
        end else begin
          pipe_hold = 1'b1;
          PC_write  = 1'b0;
          IF_write  = 1'b0;
          if (wait_cnt_reg == WAIT_LAST) begin
            timeout_next  = 1'b1;
            state_next    = RUN;
            wait_cnt_next = 10'd0;
          end else begin
            wait_cnt_next = wait_cnt_reg + 10'd1;
          end
        end
      end

      default: state_next = RUN;
    endcase

    if (reset) begin
      PC_write     = 1'b0;
      IF_write     = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_EX_bubble = 1'b0;
      ID_EX_flush  = 1'b0;
      pipe_hold    = 1'b0;
    end
  end

  assign timeout_err = timeout_reg && !reset;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_reg, perf_fl_reg, perf_mw_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_lu_reg <= 32'd0;
      perf_fl_reg <= 32'd0;
      perf_mw_reg <= 32'd0;
    end else begin
      if (ID_EX_bubble && perf_lu_reg != 32'hFFFF_FFFF) perf_lu_reg <= perf_lu_reg + 32'd1;
      if (ID_EX_flush  && perf_fl_reg != 32'hFFFF_FFFF) perf_fl_reg <= perf_fl_reg + 32'd1;
      if (pipe_hold    && perf_mw_reg != 32'hFFFF_FFFF) perf_mw_reg <= perf_mw_reg + 32'd1;
    end
  end

  assign perf_lu_stalls = perf_lu_reg;
  assign perf_flushes   = perf_fl_reg;
  assign perf_mem_wait  = perf_mw_reg;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: the driver queues expected outputs per cycle, a monitor checks them.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IF_ID_instruction;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_rd;
  logic        branch_taken, dmem_req, dmem_ready;
  logic        PC_write, IF_write, IF_ID_flush, ID_EX_bubble, ID_EX_flush, pipe_hold, timeout_err;

  int checks = 0;
  int errors = 0;

  // Expected vector order: PC_write, IF_write, IF_ID_flush, ID_EX_bubble, ID_EX_flush, pipe_hold, timeout_err
  typedef struct {
    logic [6:0] exp;
    string      name;
  } item_t;
  item_t sb[$];

  localparam logic [6:0] DEF   = 7'b1100000;
  localparam logic [6:0] ZERO  = 7'b0000000;
  localparam logic [6:0] LU    = 7'b0001000;
  localparam logic [6:0] BR    = 7'b1010100;
  localparam logic [6:0] FL    = 7'b1010000;
  localparam logic [6:0] FLH   = 7'b0010010;
  localparam logic [6:0] HOLD  = 7'b0000010;
  localparam logic [6:0] TOUT  = 7'b1100001;

  localparam logic [31:0] ADD_X5  = 32'h00528333;
  localparam logic [31:0] LUI_X5  = 32'h000012B7;
  localparam logic [31:0] SW_RS25 = 32'h00502023;
  localparam logic [31:0] ADDI_R5 = 32'h00028093;
  localparam logic [31:0] ADDI_I5 = 32'h00500093;
  localparam logic [31:0] NOP     = 32'h00000013;

  hazard_stall_ctrl #(.FLUSH_CYCLES(2), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .IF_ID_instruction(IF_ID_instruction),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .PC_write(PC_write), .IF_write(IF_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_bubble(ID_EX_bubble), .ID_EX_flush(ID_EX_flush),
    .pipe_hold(pipe_hold), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rst, input logic [31:0] instr, input logic mr, input logic [4:0] rd,
                       input logic br, input logic req, input logic rdy, input logic [6:0] exp,
                       input string name);
    item_t it;
    @(posedge clk);
    #1;
    reset = rst; IF_ID_instruction = instr; ID_EX_MemRead = mr; ID_EX_rd = rd;
    branch_taken = br; dmem_req = req; dmem_ready = rdy;
    it.exp = exp;
    it.name = name;
    sb.push_back(it);
  endtask

  initial begin : monitor
    item_t it;
    logic [6:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it  = sb.pop_front();
        got = {PC_write, IF_write, IF_ID_flush, ID_EX_bubble, ID_EX_flush, pipe_hold, timeout_err};
        checks++;
        if (got !== it.exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b", it.name, got, it.exp);
        end else begin
          $display("ok   %s: %b", it.name, got);
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1; IF_ID_instruction = NOP; ID_EX_MemRead = 1'b0; ID_EX_rd = 5'd0;
    branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;

    drive(1, NOP, 0, 0, 0, 0, 0, ZERO, "reset_a");
    drive(1, NOP, 0, 0, 0, 0, 0, ZERO, "reset_b");
    drive(0, NOP, 0, 0, 0, 0, 0, DEF,  "idle");

    // load-use decode
    drive(0, ADD_X5,  1, 5, 0, 0, 0, LU,  "lu_add");
    drive(0, ADD_X5,  0, 0, 0, 0, 0, DEF, "lu_add_after");
    drive(0, ADD_X5,  1, 0, 0, 0, 0, DEF, "lu_rd0");
    drive(0, LUI_X5,  1, 5, 0, 0, 0, DEF, "lu_lui");
    drive(0, SW_RS25, 1, 5, 0, 0, 0, LU,  "lu_sw_rs2");
    drive(0, ADDI_R5, 1, 5, 0, 0, 0, LU,  "lu_addi_rs1");
    drive(0, ADDI_I5, 1, 5, 0, 0, 0, DEF, "lu_addi_imm");
    drive(0, ADD_X5,  0, 5, 0, 0, 0, DEF, "lu_noload");

    // branch flush, load-use suppressed while flushing
    drive(0, NOP,    0, 0, 1, 0, 0, BR,  "br_detect");
    drive(0, ADD_X5, 1, 5, 0, 0, 0, FL,  "br_flush2");
    drive(0, NOP,    0, 0, 0, 0, 0, DEF, "br_done");

    // branch beats a memory stall; memory stall freezes the flush
    drive(0, NOP, 0, 0, 1, 1, 0, BR,  "brm_detect");
    drive(0, NOP, 0, 0, 0, 1, 0, FLH, "brm_hold");
    drive(0, NOP, 0, 0, 0, 0, 0, FL,  "brm_flush2");
    drive(0, NOP, 0, 0, 0, 0, 0, DEF, "brm_done");

    // memory wait of 3 cycles, branch ignored while waiting
    drive(0, NOP, 0, 0, 0, 1, 0, HOLD, "mw_1");
    drive(0, NOP, 0, 0, 1, 1, 0, HOLD, "mw_2_br");
    drive(0, ADD_X5, 1, 5, 0, 1, 0, HOLD, "mw_3_lu");
    drive(0, NOP, 0, 0, 0, 1, 1, DEF,  "mw_ready");
    drive(0, NOP, 0, 0, 0, 1, 1, DEF,  "mw_zero_wait");
    drive(0, NOP, 0, 0, 0, 0, 0, DEF,  "mw_idle");

    // watchdog: 64 held cycles, then the pulse
    for (int i = 0; i < 64; i++) drive(0, NOP, 0, 0, 0, 1, 0, HOLD, $sformatf("to_hold_%0d", i + 1));
    drive(0, NOP, 0, 0, 0, 0, 0, TOUT, "to_pulse");
    drive(0, NOP, 0, 0, 0, 0, 0, DEF,  "to_after");

    // reset in the middle of a wait
    for (int i = 0; i < 10; i++) drive(0, NOP, 0, 0, 0, 1, 0, HOLD, $sformatf("rst_hold_%0d", i + 1));
    drive(1, NOP, 0, 0, 0, 1, 0, ZERO, "rst_mid_wait");
    for (int i = 0; i < 60; i++) drive(0, NOP, 0, 0, 0, 0, 0, DEF, $sformatf("rst_after_%0d", i + 1));

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
